// File: rtl/cpu_types_pkg.sv
// Shared CPU types: branch target buffer entry layout, counter states and training function.
package cpu_types_pkg;

  localparam int unsigned BTB_ENTRIES = 16;
  // Tag wide enough for the smallest legal table (2 entries); larger tables zero-extend.
  localparam int unsigned BTB_TAGW    = 32 - ($clog2(2) + 2);

  localparam logic [1:0] BTB_ST_WN = 2'b01;
  localparam logic [1:0] BTB_ST_WT = 2'b10;
  localparam logic [1:0] BTB_ST_ST = 2'b11;

  typedef struct packed {
    logic                valid;
    logic [BTB_TAGW-1:0] tag;
    logic [29:0]         target;
    logic                isjump;
    logic [1:0]          ctr;
  } btb_entry_t;

  localparam btb_entry_t BTB_RESET_ENTRY = '{
    valid:  1'b0,
    tag:    '0,
    target: '0,
    isjump: 1'b0,
    ctr:    BTB_ST_WN
  };

  function automatic logic [1:0] btb_next_ctr(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    end
    return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch-side lookup and memory-stage resolve signals of the branch target buffer.
interface branch_target_buffer_if;

  logic [31:0] pc_f;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        clear;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_isjump;
  logic        m_taken;
  logic [31:0] m_target;
  logic        m_pred_taken;
  logic [31:0] m_pred_target;
  logic        btb_correct;
  logic        btb_wrongtype;

  modport master (
    output pc_f, clear, m_valid, m_pc, m_isjump, m_taken, m_target, m_pred_taken, m_pred_target,
    input  pred_hit, pred_taken, pred_target, btb_correct, btb_wrongtype
  );

  modport slave (
    input  pc_f, clear, m_valid, m_pc, m_isjump, m_taken, m_target, m_pred_taken, m_pred_target,
    output pred_hit, pred_taken, pred_target, btb_correct, btb_wrongtype
  );

endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit direction counters: combinational lookup and resolve,
// table trained at the clock edge on every resolved branch or jump.
module branch_target_buffer
  import cpu_types_pkg::*;
#(
  parameter int unsigned ENTRIES = BTB_ENTRIES
) (
  input logic          CLK,
  input logic          RST,
  branch_target_buffer_if.slave bus
);

  localparam int unsigned IDXW = $clog2(ENTRIES);

  btb_entry_t table_q [ENTRIES];

  logic [IDXW-1:0]     f_idx, m_idx;
  logic [BTB_TAGW-1:0] f_tag, m_tag;
  btb_entry_t          f_ent, m_ent;
  logic                m_hit;
  logic                correct;
  logic                unused_m_pc;

  assign unused_m_pc = ^bus.m_pc[1:0];

  always_comb begin
    f_idx = bus.pc_f[IDXW+1:2];
    m_idx = bus.m_pc[IDXW+1:2];
    f_tag = BTB_TAGW'(bus.pc_f >> (IDXW + 2));
    m_tag = BTB_TAGW'(bus.m_pc >> (IDXW + 2));
    f_ent = table_q[f_idx];
    m_ent = table_q[m_idx];
    m_hit = m_ent.valid && (m_ent.tag == m_tag);
  end

  always_comb begin
    bus.pred_hit    = f_ent.valid && (f_ent.tag == f_tag);
    bus.pred_taken  = bus.pred_hit && (f_ent.isjump || f_ent.ctr[1]);
    bus.pred_target = bus.pred_taken ? {f_ent.target, 2'b00} : bus.pc_f + 32'd4;
  end

  // Target only matters when the branch was actually taken.
  always_comb begin
    correct = (bus.m_pred_taken == bus.m_taken) &&
              (!bus.m_taken || (bus.m_pred_target == bus.m_target));
    if (!bus.m_valid) begin
      bus.btb_correct   = 1'b1;
      bus.btb_wrongtype = 1'b0;
    end else begin
      bus.btb_correct   = correct;
      bus.btb_wrongtype = !correct && !bus.m_taken;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        table_q[i] <= BTB_RESET_ENTRY;
      end
    end else if (bus.clear) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        table_q[i].valid <= 1'b0;
      end
    end else if (bus.m_valid) begin
      if (m_hit) begin
        table_q[m_idx].ctr    <= btb_next_ctr(m_ent.ctr, bus.m_taken);
        table_q[m_idx].isjump <= bus.m_isjump;
        if (bus.m_taken) begin
          table_q[m_idx].target <= bus.m_target[31:2];
        end
      end else if (bus.m_taken) begin
        table_q[m_idx] <= '{
          valid:  1'b1,
          tag:    m_tag,
          target: bus.m_target[31:2],
          isjump: bus.m_isjump,
          ctr:    bus.m_isjump ? BTB_ST_ST : BTB_ST_WT
        };
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer with hand-computed expectations.
module tb_branch_target_buffer;

  logic CLK;
  logic RST;
  int   n_cmp;
  int   n_err;

  branch_target_buffer_if bus ();

  branch_target_buffer #(
    .ENTRIES(16)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.m_valid       = 1'b0;
    bus.clear         = 1'b0;
    bus.m_isjump      = 1'b0;
    bus.m_taken       = 1'b0;
    bus.m_pred_taken  = 1'b0;
    bus.m_pc          = 32'h0;
    bus.m_target      = 32'h0;
    bus.m_pred_target = 32'h0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic isj, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    bus.m_valid       = 1'b1;
    bus.m_pc          = pc;
    bus.m_isjump      = isj;
    bus.m_taken       = tk;
    bus.m_target      = tgt;
    bus.m_pred_taken  = ptk;
    bus.m_pred_target = ptgt;
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic tk, input logic [31:0] tgt);
    bus.pc_f = pc;
    #1;
    check({tag, "_hit"}, 32'(bus.pred_hit), 32'(hit));
    check({tag, "_taken"}, 32'(bus.pred_taken), 32'(tk));
    check({tag, "_target"}, bus.pred_target, tgt);
  endtask

  task automatic res_chk(input string tag, input logic cor, input logic wt);
    check({tag, "_correct"}, 32'(bus.btb_correct), 32'(cor));
    check({tag, "_wrongtype"}, 32'(bus.btb_wrongtype), 32'(wt));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    RST   = 1'b1;
    bus.pc_f = 32'h40;
    idle();
    #12;
    look("rst", 32'h40, 1'b0, 1'b0, 32'h44);
    res_chk("rst", 1'b1, 1'b0);
    RST = 1'b0;
    tick();
    look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    // BEQ at 0x40 taken to 0x100, predicted not taken: allocates with ctr=10.
    resolve(32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44);
    res_chk("beq_alloc", 1'b0, 1'b0);
    look("beq_nobypass", 32'h40, 1'b0, 1'b0, 32'h44);
    tick();
    idle();
    look("beq_after", 32'h40, 1'b1, 1'b1, 32'h100);

    // Not-taken three times: ctr 10 -> 01 -> 00 -> 00.
    resolve(32'h40, 1'b0, 1'b0, 32'h100, 1'b1, 32'h100);
    res_chk("nt1", 1'b0, 1'b1);
    tick();
    look("nt1_after", 32'h40, 1'b1, 1'b0, 32'h44);
    resolve(32'h40, 1'b0, 1'b0, 32'h100, 1'b1, 32'h100);
    res_chk("nt2", 1'b0, 1'b1);
    tick();
    resolve(32'h40, 1'b0, 1'b0, 32'h100, 1'b0, 32'h44);
    res_chk("nt3", 1'b1, 1'b0);
    tick();
    idle();
    look("nt3_after", 32'h40, 1'b1, 1'b0, 32'h44);

    // JAL at 0x80 to 0x200: ctr=11, isjump keeps it taken after a not-taken resolve.
    resolve(32'h80, 1'b1, 1'b1, 32'h200, 1'b0, 32'h84);
    res_chk("jal_alloc", 1'b0, 1'b0);
    tick();
    idle();
    look("jal_after", 32'h80, 1'b1, 1'b1, 32'h200);
    resolve(32'h80, 1'b1, 1'b0, 32'h200, 1'b1, 32'h200);
    res_chk("jal_nt", 1'b0, 1'b1);
    tick();
    idle();
    look("jal_nt_after", 32'h80, 1'b1, 1'b1, 32'h200);
    resolve(32'h80, 1'b1, 1'b1, 32'h200, 1'b1, 32'h204);
    res_chk("jal_badtgt", 1'b0, 1'b0);
    resolve(32'h80, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200);
    res_chk("jal_good", 1'b1, 1'b0);
    tick();
    idle();

    // 0x440 aliases index 0 with 0x40; its allocation replaces the entry.
    look("alias_pre", 32'h440, 1'b0, 1'b0, 32'h444);
    resolve(32'h440, 1'b0, 1'b1, 32'h300, 1'b0, 32'h444);
    look("alias_same", 32'h440, 1'b0, 1'b0, 32'h444);
    tick();
    idle();
    look("alias_old", 32'h40, 1'b0, 1'b0, 32'h44);
    look("alias_new", 32'h440, 1'b1, 1'b1, 32'h300);
    resolve(32'h440, 1'b0, 1'b1, 32'h380, 1'b1, 32'h300);
    look("alias_retgt_same", 32'h440, 1'b1, 1'b1, 32'h300);
    tick();
    idle();
    look("alias_retgt", 32'h440, 1'b1, 1'b1, 32'h380);

    // Clear wins over a same-cycle allocating update.
    bus.clear = 1'b1;
    resolve(32'h100, 1'b0, 1'b1, 32'h500, 1'b0, 32'h104);
    tick();
    idle();
    look("clr_80", 32'h80, 1'b0, 1'b0, 32'h84);
    look("clr_440", 32'h440, 1'b0, 1'b0, 32'h444);
    look("clr_100", 32'h100, 1'b0, 1'b0, 32'h104);

    // Asynchronous reset mid-update.
    resolve(32'h80, 1'b1, 1'b1, 32'h200, 1'b0, 32'h84);
    tick();
    look("pre_rst", 32'h80, 1'b1, 1'b1, 32'h200);
    resolve(32'h80, 1'b1, 1'b1, 32'h240, 1'b1, 32'h200);
    RST = 1'b1;
    look("rst_async", 32'h80, 1'b0, 1'b0, 32'h84);
    tick();
    idle();
    #2;
    RST = 1'b0;
    tick();
    look("rst_after", 32'h80, 1'b0, 1'b0, 32'h84);
    res_chk("rst_after", 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
